// File: rtl/riscv_regfile_sb_pkg.sv
// Shared definitions for the scoreboarded RISC-V register file:
// default sizes, reset PC, ABI register indexes and the counter op encoding.
package riscv_regfile_sb_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_COUNT_DEF = 32;
  localparam int REG_IDX_W     = $clog2(REG_COUNT_DEF);
  localparam int PEND_W_DEF    = 2;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  // ABI names for the architectural registers
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd2;
  localparam logic [REG_IDX_W-1:0] REG_GP   = 5'd3;
  localparam logic [REG_IDX_W-1:0] REG_TP   = 5'd4;
  localparam logic [REG_IDX_W-1:0] REG_T0   = 5'd5;
  localparam logic [REG_IDX_W-1:0] REG_T1   = 5'd6;
  localparam logic [REG_IDX_W-1:0] REG_T2   = 5'd7;
  localparam logic [REG_IDX_W-1:0] REG_S0   = 5'd8;
  localparam logic [REG_IDX_W-1:0] REG_S1   = 5'd9;
  localparam logic [REG_IDX_W-1:0] REG_A0   = 5'd10;
  localparam logic [REG_IDX_W-1:0] REG_A1   = 5'd11;

  // Per-cycle action of one pending-write counter
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/riscv_regfile_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// An increment while full or a decrement while empty is dropped; a
// simultaneous valid increment and decrement leave the count unchanged.
module riscv_sb_counter
  import riscv_regfile_sb_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              full,
  output logic              nonzero
);

  logic    inc_ok;
  logic    dec_ok;
  cnt_op_e op;

  assign full    = &cnt;
  assign nonzero = |cnt;
  assign inc_ok  = inc & ~full;
  assign dec_ok  = dec & nonzero;

  // Decode the effective action; inc and dec together cancel out
  always_comb begin
    op = CNT_HOLD;
    if (inc_ok && !dec_ok) begin
      op = CNT_INC;
    end else if (dec_ok && !inc_ok) begin
      op = CNT_DEC;
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_INC: cnt <= cnt + PEND_W'(1);
        CNT_DEC: cnt <= cnt - PEND_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/riscv_regfile_sb.sv
// RISC-V register file with PC and a per-register pending-write scoreboard.
// x0 reads as zero and is never busy. Issue reserves a destination, write-back
// retires it; a write-back with nothing pending still writes and sets the
// sticky sb_error flag.
// Optional build macro REGFILE_BYPASS_EN: forward same-cycle write-back data
// onto the read ports and report busy as the post-retire state.
module riscv_regfile_sb
  import riscv_regfile_sb_pkg::*;
#(
  parameter int                XLEN      = XLEN_DEF,
  parameter int                REG_COUNT = REG_COUNT_DEF,
  parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int                PEND_W    = PEND_W_DEF,
  localparam int               IDX_W     = $clog2(REG_COUNT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_we,
  input  logic [XLEN-1:0]  pc_next,
  output logic [XLEN-1:0]  pc_val,
  input  logic [IDX_W-1:0] rs1_index,
  input  logic [IDX_W-1:0] rs2_index,
  output logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_rd,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_index,
  input  logic [XLEN-1:0]  wb_data,
  output logic             sb_error
);

  logic [XLEN-1:0]   regs     [REG_COUNT];
  logic [PEND_W-1:0] cnt_mem  [REG_COUNT];
  logic [REG_COUNT-1:0] full_vec;
  logic [REG_COUNT-1:0] nz_vec;

  logic acc;
  logic ret;
  logic wb_live;

  // A real, writable register: not x0 and inside the implemented range
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < 32'(REG_COUNT));
  endfunction

  // Read data for one port, with optional same-cycle write-back forwarding
  function automatic logic [XLEN-1:0] read_data(input logic [IDX_W-1:0] idx);
    logic [XLEN-1:0] d;
    d = '0;
    if (idx_ok(idx)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (wb_index == idx)) begin
        d = wb_data;
      end else begin
        d = regs[idx];
      end
`else
      d = regs[idx];
`endif
    end
    return d;
  endfunction

  // Busy for one port; with forwarding, reflects the count after this edge
  function automatic logic read_busy(input logic [IDX_W-1:0] idx);
    logic b;
    b = 1'b0;
    if (idx_ok(idx)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (wb_index == idx)) begin
        b = (cnt_mem[idx] > PEND_W'(1)) ||
            ((cnt_mem[idx] == PEND_W'(1)) && acc && (issue_rd == idx));
      end else begin
        b = nz_vec[idx];
      end
`else
      b = nz_vec[idx];
`endif
    end
    return b;
  endfunction

  assign issue_ready = ~(idx_ok(issue_rd) & full_vec[issue_rd]);
  assign acc         = issue_valid & issue_ready & idx_ok(issue_rd);
  assign wb_live     = wb_valid & idx_ok(wb_index);
  assign ret         = wb_live & nz_vec[wb_index];

  // x0 has no counter; tie its slot off
  assign cnt_mem[0]  = '0;
  assign full_vec[0] = 1'b0;
  assign nz_vec[0]   = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_cnt
    riscv_sb_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (acc && (issue_rd == IDX_W'(r))),
      .dec     (ret && (wb_index == IDX_W'(r))),
      .cnt     (cnt_mem[r]),
      .full    (full_vec[r]),
      .nonzero (nz_vec[r])
    );
  end

  // Combinational read ports
  always_comb begin
    rs1      = read_data(rs1_index);
    rs2      = read_data(rs2_index);
    rs1_busy = read_busy(rs1_index);
    rs2_busy = read_busy(rs2_index);
  end

  // Program counter
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_val <= RESET_PC;
    end else if (pc_we) begin
      pc_val <= pc_next;
    end
  end

  // Register array: contents survive reset, but no write lands during reset
  always_ff @(posedge clock) begin
    if (!reset && wb_live) begin
      regs[wb_index] <= wb_data;
    end
  end

  // Sticky flag for a write-back that had no matching reservation
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (wb_live && !nz_vec[wb_index]) begin
      sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb (RESET_PC = 0x100, 32 x 32-bit,
// PEND_W = 2). A behavioural model follows every clock edge; written values
// are queued and popped when read back.
module tb_riscv_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [31:0] pc_val;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_index;
  logic [31:0] wb_data;
  logic        sb_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;
  logic [31:0] m_pc;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q [$];

  always #5 clock = ~clock;

  riscv_regfile_sb #(
    .XLEN      (32),
    .REG_COUNT (32),
    .RESET_PC  (32'h100),
    .PEND_W    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .pc_val      (pc_val),
    .rs1_index   (rs1_index),
    .rs2_index   (rs2_index),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_index    (wb_index),
    .wb_data     (wb_data),
    .sb_error    (sb_error)
  );

  // Advance the model with the current inputs, then take one clock edge
  task automatic tick();
    logic acc;
    logic ret;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      m_pc  = 32'h100;
    end else begin
      acc = issue_valid && (issue_rd != 0) && (m_cnt[issue_rd] < 3);
      ret = wb_valid && (wb_index != 0) && (m_cnt[wb_index] > 0);
      if (wb_valid && (wb_index != 0)) begin
        m_regs[wb_index] = wb_data;
        exp_q.push_back('{int'(wb_index), wb_data});
        if (!ret) m_err = 1'b1;
      end
      if (acc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
      if (ret) m_cnt[wb_index] = m_cnt[wb_index] - 1;
      if (pc_we) m_pc = pc_next;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    n_checks++;
    if (pc_val !== 32'h100) $display("FAIL reset_pc: got %h want %h", pc_val, 32'h100);
    else n_pass++;
    n_checks++;
    if (sb_error !== 1'b0) $display("FAIL reset_sb_error: got %b want 0", sb_error);
    else n_pass++;
    n_checks++;
    if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready);
    else n_pass++;
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      rs1_index = 5'(r);
      rs2_index = 5'(31 - r);
      #1;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_busy: got %0d busy registers want 0", bad);
    else n_pass++;
    pc_we   = 1'b1;
    pc_next = 32'h104;
    tick();
    pc_we = 1'b0;
    n_checks++;
    if (pc_val !== 32'h104) $display("FAIL pc_load: got %h want %h", pc_val, 32'h104);
    else n_pass++;
    pc_next = 32'h999;
    tick();
    n_checks++;
    if (pc_val !== m_pc) $display("FAIL pc_hold: got %h want %h", pc_val, m_pc);
    else n_pass++;
  endtask

  task automatic test_readwrite();
    wr_t e;
    exp_q.delete();
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1;
    wb_index = 5'd5;
    wb_data  = 32'hDEADBEEF;
    tick();
    wb_index = 5'd6;
    wb_data  = 32'h0BADF00D;
    tick();
    wb_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rs1_index = 5'(e.idx);
      rs2_index = 5'd0;
      #1;
      n_checks++;
      if (rs1 !== e.data) $display("FAIL rd_rs1_x%0d: got %h want %h", e.idx, rs1, e.data);
      else n_pass++;
      n_checks++;
      if (rs2 !== 32'h0) $display("FAIL rd_rs2_x0: got %h want 0", rs2);
      else n_pass++;
    end
    wb_valid  = 1'b1;
    wb_index  = 5'd0;
    wb_data   = 32'h1234;
    rs1_index = 5'd0;
    rs2_index = 5'd5;
    #1;
    n_checks++;
    if (rs1 !== 32'h0 || rs1_busy !== 1'b0) $display("FAIL x0_during_wb: got %h/%b want 0/0", rs1, rs1_busy);
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (rs1 !== 32'h0) $display("FAIL x0_after_wb: got %h want 0", rs1);
    else n_pass++;
    n_checks++;
    if (rs2 !== m_regs[5]) $display("FAIL x5_keep: got %h want %h", rs2, m_regs[5]);
    else n_pass++;
    n_checks++;
    if (sb_error !== m_err) $display("FAIL wb_sb_error: got %b want %b", sb_error, m_err);
    else n_pass++;
  endtask

  task automatic test_issue_saturate();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1_index   = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (issue_ready !== 1'b1) $display("FAIL sat_ready_%0d: got %b want 1", k, issue_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (rs1_busy !== (m_cnt[7] != 0)) $display("FAIL sat_busy_%0d: got %b want %b", k, rs1_busy, m_cnt[7] != 0);
      else n_pass++;
    end
    n_checks++;
    if (issue_ready !== 1'b0) $display("FAIL sat_full_ready: got %b want 0", issue_ready);
    else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++;
    if (rs1_busy !== 1'b1) $display("FAIL sat_hold_busy: got %b want 1", rs1_busy);
    else n_pass++;
    wb_valid = 1'b1;
    wb_index = 5'd7;
    for (int k = 0; k < 3; k++) begin
      wb_data = 32'h700 + 32'(k);
      tick();
      n_checks++;
      if (rs1_busy !== (m_cnt[7] != 0)) $display("FAIL sat_retire_%0d: got %b want %b", k, rs1_busy, m_cnt[7] != 0);
      else n_pass++;
    end
    wb_valid = 1'b0;
    n_checks++;
    if (sb_error !== 1'b0) $display("FAIL sat_sb_error: got %b want 0", sb_error);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_rd = 5'd10;
    tick();
    issue_rd  = 5'd9;
    wb_valid  = 1'b1;
    wb_index  = 5'd9;
    wb_data   = 32'h99;
    rs1_index = 5'd9;
    rs2_index = 5'd10;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1) $display("FAIL same_busy_comb: got %b want 1", rs1_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (rs1_busy !== (m_cnt[9] != 0)) $display("FAIL same_busy_after: got %b want %b", rs1_busy, m_cnt[9] != 0);
    else n_pass++;
    wb_index = 5'd10;
    wb_data  = 32'h1010;
    tick();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    n_checks++;
    if (rs2_busy !== 1'b0) $display("FAIL diff_busy10: got %b want 0", rs2_busy);
    else n_pass++;
    n_checks++;
    if (rs2 !== 32'h1010) $display("FAIL diff_data10: got %h want %h", rs2, 32'h1010);
    else n_pass++;
    wb_valid = 1'b1;
    wb_index = 5'd9;
    tick();
    n_checks++;
    if (rs1_busy !== 1'b1) $display("FAIL diff_cnt9_two: got %b want 1", rs1_busy);
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (rs1_busy !== 1'b0) $display("FAIL diff_cnt9_clear: got %b want 0", rs1_busy);
    else n_pass++;
    n_checks++;
    if (sb_error !== m_err) $display("FAIL same_sb_error: got %b want %b", sb_error, m_err);
    else n_pass++;
  endtask

  task automatic test_error();
    wr_t e;
    exp_q.delete();
    wb_valid  = 1'b1;
    wb_index  = 5'd12;
    wb_data   = 32'hCAFE0012;
    rs1_index = 5'd12;
    tick();
    wb_valid = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (rs1 !== e.data) $display("FAIL err_data: got %h want %h", rs1, e.data);
    else n_pass++;
    n_checks++;
    if (sb_error !== 1'b1) $display("FAIL err_set: got %b want 1", sb_error);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (sb_error !== 1'b1) $display("FAIL err_sticky: got %b want 1", sb_error);
    else n_pass++;
    issue_valid = 1'b1;
    issue_rd    = 5'd13;
    tick();
    reset    = 1'b1;
    issue_rd = 5'd14;
    pc_we    = 1'b1;
    pc_next  = 32'h200;
    tick();
    reset       = 1'b0;
    issue_valid = 1'b0;
    pc_we       = 1'b0;
    rs1_index   = 5'd13;
    rs2_index   = 5'd14;
    #1;
    n_checks++;
    if (pc_val !== 32'h100) $display("FAIL mid_reset_pc: got %h want %h", pc_val, 32'h100);
    else n_pass++;
    n_checks++;
    if (sb_error !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", sb_error);
    else n_pass++;
    n_checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) $display("FAIL mid_reset_busy: got %b/%b want 0/0", rs1_busy, rs2_busy);
    else n_pass++;
    wb_valid = 1'b1;
    wb_index = 5'd13;
    wb_data  = 32'h13;
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (sb_error !== m_err) $display("FAIL post_reset_wb_err: got %b want %b", sb_error, m_err);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (sb_error !== 1'b0) $display("FAIL err_clear: got %b want 0", sb_error);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1;
    wb_index = 5'd3;
    wb_data  = 32'h11;
    tick();
    wb_valid    = 1'b0;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    wb_valid  = 1'b1;
    wb_index  = 5'd3;
    wb_data   = 32'h55;
    rs1_index = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'h55;
    exp_b = 1'b0;
`else
    exp_d = 32'h11;
    exp_b = 1'b1;
`endif
    n_checks++;
    if (rs1 !== exp_d) $display("FAIL byp_data: got %h want %h", rs1, exp_d);
    else n_pass++;
    n_checks++;
    if (rs1_busy !== exp_b) $display("FAIL byp_busy: got %b want %b", rs1_busy, exp_b);
    else n_pass++;
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (rs1 !== 32'h55 || rs1_busy !== 1'b0) $display("FAIL byp_after: got %h/%b want 55/0", rs1, rs1_busy);
    else n_pass++;
    issue_valid = 1'b1;
    tick();
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1;
    wb_data  = 32'h66;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1) $display("FAIL byp_cnt2_busy: got %b want 1", rs1_busy);
    else n_pass++;
    tick();
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (rs1_busy !== 1'b0 || sb_error !== m_err) $display("FAIL byp_drain: got %b/%b want 0/%b", rs1_busy, sb_error, m_err);
    else n_pass++;
  endtask

  initial begin
    reset       = 1'b1;
    pc_we       = 1'b0;
    pc_next     = '0;
    rs1_index   = '0;
    rs2_index   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = 1'b0;
    wb_index    = '0;
    wb_data     = '0;
    m_err       = 1'b0;
    m_pc        = 32'h100;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_readwrite();
    test_issue_saturate();
    test_same_cycle();
    test_error();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
Parametrised successor to the core register file. It holds the program counter and XLEN-wide general registers, with x0 hard-wired to zero, two read ports and one write-back port. It adds a per-register pending-write scoreboard so a pipelined or multi-cycle core can issue several instructions before their results return. It sits between decode/issue (read, reserve) and write-back (retire) in the RISC-V core.

Parameters:
XLEN, 32, data width of PC and registers
REG_COUNT, 32, number of architectural registers including x0 (16 for RV32E)
RESET_PC, 0, PC value loaded on reset
PEND_W, 2, width of per-register pending counter; max outstanding writes per register = 2^PEND_W-1

Ports:
clock  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_we  in  1  load pc_next into PC
pc_next  in  XLEN  next PC value
pc_val  out  XLEN  current PC
rs1_index  in  $clog2(REG_COUNT)  read port 1 address
rs2_index  in  $clog2(REG_COUNT)  read port 2 address
rs1  out  XLEN  read data 1, combinational
rs2  out  XLEN  read data 2, combinational
rs1_busy  out  1  rs1 has an outstanding write
rs2_busy  out  1  rs2 has an outstanding write
issue_valid  in  1  reserve destination issue_rd
issue_rd  in  $clog2(REG_COUNT)  destination being reserved
issue_ready  out  1  reservation can be accepted this cycle
wb_valid  in  1  write-back strobe
wb_index  in  $clog2(REG_COUNT)  write-back destination
wb_data  in  XLEN  write-back value
sb_error  out  1  sticky: write-back to a register with zero pending count

Behaviour:
- Reset, synchronous, when reset=1 at the edge:
  - PC := RESET_PC.
  - All pending counters := 0.
  - sb_error := 0.
  - Register contents are not reset.
  - Reset overrides every other input in the same cycle.
- PC: at each edge with pc_we=1, pc := pc_next; otherwise PC holds.
- Reads: combinational, no latency. Index 0 always returns 0 with busy=0. Indexes ≥ REG_COUNT return 0 with busy=0.
- Write-back: at each edge with wb_valid=1 and wb_index≠0, regs[wb_index] := wb_data. A write-back to x0 is ignored and leaves sb_error unchanged.
- Pending counter cnt[r] per register r=1..REG_COUNT-1. Issue accepted (acc) = issue_valid & issue_ready & issue_rd≠0.
- issue_ready = (issue_rd==0) | (cnt[issue_rd] != all-ones). When the counter is saturated it is 0; the issuer must hold and retry. issue_ready does not depend on issue_valid.
- Retire (ret) = wb_valid & wb_index≠0 & cnt[wb_index]≠0.
- Counter update at each edge:
  - acc only: +1.
  - ret only: -1.
  - acc and ret on the same register: unchanged.
  - acc and ret on different registers: each updated independently.
- wb_valid with wb_index≠0 and cnt[wb_index]==0: data is still written, counter stays 0, sb_error := 1 (sticky until reset).
- busy = cnt[index]≠0, evaluated on current (pre-edge) state unless bypass is enabled.
- Reset asserted mid-sequence discards all reservations; writes arriving after reset raise sb_error.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined:
  - When wb_valid=1 and wb_index==rsN_index≠0, rsN returns wb_data in the same cycle.
  - rsN_busy reports whether the counter will still be nonzero after this retire, i.e. cnt>1, or cnt==1 with a same-register issue accepted this cycle.
- Undefined: rsN returns the stored value, and busy reflects the current counter only. The consumer sees the written value one cycle later.

Decomposition:
- Shared package/header: XLEN default, REG_COUNT default, register index width, RESET_PC, ABI index constants (REG_ZERO, REG_RA, REG_SP, ...).
- Sub-module riscv_sb_counter: one saturating up/down counter with inc, dec, full and nonzero outputs, instantiated REG_COUNT-1 times via generate.
- Register array and PC stay in the top module.

Test Plan:
- Reset with RESET_PC=0x100, then pc_we=1, pc_next=0x104 -> pc_val=0x100 after reset, 0x104 one cycle later; all busy=0; sb_error=0.
- wb x5=0xDEADBEEF, then read rs1_index=5 and rs2_index=0 -> rs1=0xDEADBEEF, rs2=0; wb x0=0x1234 -> rs read of 0 still returns 0.
- Issue rd=7 three times (PEND_W=2) -> rs1_busy(7)=1 and issue_ready=1 until cnt=3, then issue_ready=0; three wb to x7 -> busy clears after the third.
- Same-cycle issue rd=9 and wb x9 with cnt=1 -> cnt stays 1, busy stays 1; issue rd=9 with wb x10 -> cnt9=2, cnt10 decremented.
- wb x12 with cnt=0 -> regs[12] updated, sb_error=1 held across later cycles until reset.
- With REGFILE_BYPASS_EN, cnt[3]=1, wb x3=0x55 and rs1_index=3 in the same cycle -> rs1=0x55 and rs1_busy=0 combinationally. Without the macro -> rs1=old value, rs1_busy=1.
